// File: rtl/if_id_queue.sv
// ============================================================================
//  Module   : if_id_queue
//  Brief    : Decoupling FIFO between the IF and ID pipeline stages. Holds
//             (PC+4, instruction) pairs, presents the head with a registered
//             one-cycle first-word latency, and drains instantly on flush.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_id_queue #(
  parameter int                PC_W   = 12,
  parameter int                INSN_W = 32,
  parameter int                DEPTH  = 4,
  parameter logic [INSN_W-1:0] NOP    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [PC_W-1:0]            in_pc_4,
  input  logic [INSN_W-1:0]          in_insn,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [PC_W-1:0]            out_pc_4,
  output logic [INSN_W-1:0]          out_insn,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  // Storage is intentionally left unreset; occupancy alone defines validity.
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];
  logic [INSN_W-1:0] r_mem_insn [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_push;
  logic              w_pop;

  // Handshake qualifiers derive only from registered occupancy, so there is
  // no combinational path from out_ready to in_ready or from in_* to out_*.
  assign w_in_ready  = (r_count < c_DEPTH);
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid  && w_in_ready  && !flush && !rst;
  assign w_pop       = out_ready && w_out_valid && !flush && !rst;

  // Pointer and occupancy update: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage write at the tail slot on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]   <= in_pc_4;
      r_mem_insn[r_wr_ptr] <= in_insn;
    end
  end

  // Head presentation: real entry when occupied, otherwise a zero PC and NOP.
  always_comb begin
    out_pc_4 = '0;
    out_insn = NOP;
    if (w_out_valid) begin
      out_pc_4 = r_mem_pc[r_rd_ptr];
      out_insn = r_mem_insn[r_rd_ptr];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
// ============================================================================
//  Module   : tb_if_id_queue
//  Brief    : Directed self-checking bench for if_id_queue (DEPTH=4, NOP=0).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_id_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_pc_4;
  logic [31:0] in_insn;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [11:0] out_pc_4;
  logic [31:0] out_insn;
  logic [2:0]  count;

  int n_pass;
  int n_total;

  if_id_queue dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pc_4   (in_pc_4),
    .in_insn   (in_insn),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc_4  (out_pc_4),
    .out_insn  (out_insn),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] pc, input logic [31:0] insn);
    in_valid = 1'b1;
    in_pc_4  = pc;
    in_insn  = insn;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] insn);
    check(tag, out_insn, insn);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_pc_4   = '0;
    in_insn   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_count",   count,     0);
    check("rst_inready", in_ready,  1);
    check("rst_ovalid",  out_valid, 0);
    check("rst_pc",      out_pc_4,  0);
    check("rst_insn",    out_insn,  0);

    // First-word latency
    push(12'h004, 32'h2008_0001);
    check("fw_ovalid", out_valid, 1);
    check("fw_insn",   out_insn,  32'h2008_0001);
    check("fw_pc",     out_pc_4,  12'h004);
    check("fw_count",  count,     1);
    pop_expect("fw_pop", 32'h2008_0001);
    check("fw_empty", count, 0);

    // Fill past full; fifth push must be dropped, head stays put
    for (int i = 1; i <= 5; i++) begin
      push(12'(i * 4), 32'h1000 + 32'(i));
      if (i == 4) begin
        check("full_inready", in_ready, 0);
        check("full_count",   count,    4);
      end
    end
    check("ovf_count", count,    4);
    check("ovf_head",  out_insn, 32'h1001);
    check("ovf_pc",    out_pc_4, 12'h004);
    for (int k = 1; k <= 4; k++) begin
      pop_expect("ovf_order", 32'h1000 + 32'(k));
    end
    check("ovf_drained", count,     0);
    check("ovf_ovalid",  out_valid, 0);

    // Full queue with push+pop: pop only, slot usable next cycle
    for (int i = 1; i <= 4; i++) begin
      push(12'(i), 32'h2000 + 32'(i));
    end
    in_valid  = 1'b1;
    in_pc_4   = 12'h050;
    in_insn   = 32'h2005;
    out_ready = 1'b1;
    step();
    check("fp_count3", count,    3);
    check("fp_head",   out_insn, 32'h2002);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("fp_count4", count, 4);
    for (int k = 2; k <= 5; k++) begin
      pop_expect("fp_order", 32'h2000 + 32'(k));
    end
    check("fp_drained", count, 0);

    // Flush overrides concurrent push and pop
    for (int i = 1; i <= 3; i++) begin
      push(12'(i), 32'h3000 + 32'(i));
    end
    check("fl_pre", count, 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc_4   = 12'h0AA;
    in_insn   = 32'h3009;
    out_ready = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fl_count",   count,     0);
    check("fl_ovalid",  out_valid, 0);
    check("fl_insn",    out_insn,  0);
    check("fl_pc",      out_pc_4,  0);
    check("fl_inready", in_ready,  1);
    step();
    check("fl_absent", count, 0);

    // Streaming push+pop at count=1, wrapping pointers
    push(12'h100, 32'h4000);
    for (int k = 0; k < 10; k++) begin
      check("st_head", out_insn, 32'h4000 + 32'(k));
      in_valid  = 1'b1;
      in_pc_4   = 12'h101 + 12'(k);
      in_insn   = 32'h4001 + 32'(k);
      out_ready = 1'b1;
      step();
      check("st_count", count, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("st_last_insn", out_insn, 32'h400A);
    check("st_last_pc",   out_pc_4, 12'h10A);
    pop_expect("st_drain", 32'h400A);
    check("st_empty", count, 0);

    // Reset mid-operation beats a concurrent push
    push(12'h010, 32'h5001);
    push(12'h014, 32'h5002);
    check("rs_pre", count, 2);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_insn  = 32'h5003;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rs_count",   count,     0);
    check("rs_inready", in_ready,  1);
    check("rs_pc",      out_pc_4,  0);
    check("rs_ovalid",  out_valid, 0);
    check("rs_insn",    out_insn,  0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
